// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA stream receiver: locks pixel/line counters to sync and emits coordinate-tagged samples
module vga_rx #(
    parameter int   CLK_PER_PIX = 4,
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_POL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [2:0] rgb_i,
    input  logic       err_clr,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] rgb_o,
    output logic       frame_start,
    output logic       locked,
    output logic       err_h,
    output logic       err_v
);
    localparam int            PW     = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam logic [PW-1:0] PH_MAX = PW'(CLK_PER_PIX - 1);
    localparam logic [PW-1:0] PH_ONE = PW'(1);
    localparam logic [9:0]    H_MAX  = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]    V_MAX  = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]    H_REF  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]    V_REF  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]    H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS  = 10'(V_DISPLAY);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [1:0]    hs_sync_q, vs_sync_q;
    logic          hs_prev_q, vs_prev_q;
    logic [2:0]    rgb_s1_q, rgb_s2_q;
    logic [PW-1:0] ph_q, ph_d, ph_run;
    logic [9:0]    hc_q, hc_d, hc_run;
    logic [9:0]    vc_q, vc_d, vc_run;
    logic          err_h_q, err_h_d, err_v_q, err_v_d;
    logic          pix_valid_q, frame_start_q;
    logic [9:0]    pix_x_q, pix_y_q;
    logic [2:0]    rgb_q;
    logic          hs_edge, vs_edge, at_h_ref, at_v_ref, h_mis, v_mis, sample;

    assign hs_edge  = (hs_sync_q[1] == SYNC_POL) && (hs_prev_q != SYNC_POL);
    assign vs_edge  = (vs_sync_q[1] == SYNC_POL) && (vs_prev_q != SYNC_POL);
    assign at_h_ref = (ph_q == '0) && (hc_q == H_REF);
    assign at_v_ref = (ph_q == '0) && (hc_q == '0) && (vc_q == V_REF);
    // A mismatch is either an edge off its reference point or a reference point without its edge
    assign h_mis    = hs_edge != at_h_ref;
    assign v_mis    = vs_edge != at_v_ref;
    assign sample   = (state_q == LOCKED) && (ph_q == '0) && (hc_q < H_VIS) && (vc_q < V_VIS);

    always_comb begin
        ph_run = (ph_q == PH_MAX) ? '0 : ph_q + PH_ONE;
        hc_run = hc_q;
        vc_run = vc_q;
        if (ph_q == PH_MAX) begin
            hc_run = (hc_q == H_MAX) ? '0 : hc_q + 10'd1;
            if (hc_q == H_MAX) begin
                vc_run = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_run;
        hc_d    = hc_run;
        vc_d    = vc_run;
        err_h_d = err_h_q & ~err_clr;
        err_v_d = err_v_q & ~err_clr;
        if (vs_edge) begin
            ph_d = PH_ONE;
            hc_d = '0;
            vc_d = V_REF;
        end else if (hs_edge) begin
            ph_d = PH_ONE;
            hc_d = H_REF;
        end
        unique case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d = ACQUIRE;
                end else begin
                    ph_d = '0;
                    hc_d = '0;
                    vc_d = '0;
                end
            end
            ACQUIRE: begin
                if (vs_edge && at_v_ref) state_d = LOCKED;
            end
            LOCKED: begin
                if (h_mis) err_h_d = 1'b1;
                if (v_mis) err_v_d = 1'b1;
                if (h_mis || v_mis) state_d = ACQUIRE;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SEARCH;
            hs_sync_q     <= '0;
            vs_sync_q     <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            rgb_s1_q      <= '0;
            rgb_s2_q      <= '0;
            ph_q          <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            hs_sync_q     <= {hs_sync_q[0], hsync_i};
            vs_sync_q     <= {vs_sync_q[0], vsync_i};
            hs_prev_q     <= hs_sync_q[1];
            vs_prev_q     <= vs_sync_q[1];
            rgb_s1_q      <= rgb_i;
            rgb_s2_q      <= rgb_s1_q;
            ph_q          <= ph_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
            pix_valid_q   <= sample;
            frame_start_q <= sample && (hc_q == '0) && (vc_q == '0);
            if (sample) begin
                pix_x_q <= hc_q;
                pix_y_q <= vc_q;
                rgb_q   <= rgb_s2_q;
            end
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign rgb_o       = rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;
endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - directed bench for vga_rx on a reduced 16x9-line raster
module tb_vga_rx;
    localparam int CPP = 2;
    localparam int HD = 8, HF = 2, HS = 3, HB = 3;
    localparam int VD = 4, VF = 2, VS = 1, VB = 2;
    localparam int HT = HD + HF + HS + HB;   // 16 pixels per line
    localparam int VT = VD + VF + VS + VB;   // 9 lines per frame, 288 clocks
    localparam int H_REF = HD + HF;          // 10
    localparam int V_REF = VD + VF;          // 6

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync_i = 1'b0, vsync_i = 1'b0, err_clr = 1'b0;
    logic [2:0] rgb_i = '0;
    logic       pix_valid, frame_start, locked, err_h, err_v;
    logic [9:0] pix_x, pix_y;
    logic [2:0] rgb_o;

    vga_rx #(
        .CLK_PER_PIX(CPP), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .hsync_i(hsync_i), .vsync_i(vsync_i), .rgb_i(rgb_i),
        .err_clr(err_clr), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .rgb_o(rgb_o),
        .frame_start(frame_start), .locked(locked), .err_h(err_h), .err_v(err_v)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int sx = 0, sy = 0, sp = 0;
    int hx[4], hy[4], hp[4];
    int vs_cnt = 0, vs_cyc = 0, mark_cnt = 0, mark_cyc = 0;
    bit shift_req = 0, skip_req = 0, dual_req = 0, vskip_req = 0;
    bit line_shift = 0, line_skip = 0, line_dual = 0, frame_vskip = 0;
    bit win = 0;
    int n_strobe, n_fs, n_last, valid_bad, data_bad, color_bad;
    int lk_rise = 0, lk_fall = 0, eh_rise = 0, ev_rise = 0;
    bit lk_prev = 0, eh_prev = 0, ev_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source raster: pins for position (sx,sy,sp) are driven just after each rising edge
    initial begin
        for (int i = 0; i < 4; i++) begin hx[i] = -1; hy[i] = -1; hp[i] = -1; end
        forever begin
            bit hs_on, vs_on;
            @(posedge clk);
            cyc++;
            #1;
            if (sx == 0 && sp == 0) begin
                line_shift = shift_req; shift_req = 0;
                line_skip  = skip_req;  skip_req  = 0;
                line_dual  = (sy == V_REF) && dual_req;
                if (line_dual) dual_req = 0;
                frame_vskip = (sy == V_REF) && vskip_req;
                if (frame_vskip) vskip_req = 0;
            end
            if (line_skip)       hs_on = 0;
            else if (line_shift) hs_on = (sx >= H_REF + 1) && (sx < H_REF + 1 + HS);
            else                 hs_on = (sx >= H_REF) && (sx < H_REF + HS);
            if (line_dual && sx == 0) hs_on = 1;
            vs_on = (sy >= V_REF) && (sy < V_REF + VS) && !frame_vskip;
            hsync_i = hs_on;
            vsync_i = vs_on;
            rgb_i   = 3'(sx);
            if (vs_on && sy == V_REF && sx == 0 && sp == 0) begin vs_cnt++; vs_cyc = cyc; end
            if ((line_shift || line_skip) && sx == H_REF && sp == 0) begin mark_cnt++; mark_cyc = cyc; end
            if (frame_vskip && sx == 0 && sp == 0) begin mark_cnt++; mark_cyc = cyc; end
            for (int i = 3; i > 0; i--) begin hx[i] = hx[i-1]; hy[i] = hy[i-1]; hp[i] = hp[i-1]; end
            hx[0] = sx; hy[0] = sy; hp[0] = sp;
            sp++;
            if (sp == CPP) begin
                sp = 0; sx++;
                if (sx == HT) begin
                    sx = 0; sy++;
                    if (sy == VT) sy = 0;
                end
            end
        end
    end

    // Outputs at negedge relate to the pins driven three edges earlier (hist slot 3)
    always @(negedge clk) begin
        if (win) begin
            bit exp_v;
            exp_v = (hp[3] == 0) && (hx[3] >= 0) && (hx[3] < HD) && (hy[3] >= 0) && (hy[3] < VD);
            if (pix_valid != exp_v) valid_bad++;
            if (pix_valid) begin
                n_strobe++;
                if (int'(pix_x) != hx[3] || int'(pix_y) != hy[3] || rgb_o != 3'(hx[3])) data_bad++;
                if (rgb_o != pix_x[2:0]) color_bad++;
                if (pix_x == 10'd7 && rgb_o == 3'b111) n_last++;
            end
            if (frame_start) begin
                n_fs++;
                if (!pix_valid || pix_x != 10'd0 || pix_y != 10'd0) data_bad++;
            end
        end
        if (locked && !lk_prev) lk_rise = cyc;
        if (!locked && lk_prev) lk_fall = cyc;
        if (err_h && !eh_prev) eh_rise = cyc;
        if (err_v && !ev_prev) ev_rise = cyc;
        lk_prev = locked; eh_prev = err_h; ev_prev = err_v;
    end

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    task automatic wait_vs(input int n);
        int target, budget;
        target = vs_cnt + n;
        budget = 0;
        while (vs_cnt < target && budget < 400 * n + 400) begin @(posedge clk); #2; budget++; end
        check("vs_wait", vs_cnt >= target, 1);
    endtask

    task automatic wait_mark();
        int target, budget;
        target = mark_cnt + 1;
        budget = 0;
        while (mark_cnt < target && budget < 1000) begin @(posedge clk); #2; budget++; end
        check("mark_wait", mark_cnt >= target, 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2; err_clr = 1'b1;
        @(posedge clk); #2; err_clr = 1'b0;
        wait_clk(2);
    endtask

    // Release reset, then expect lock on the second vsync; that vsync line also carries a coincident hsync
    task automatic lock_seq();
        @(posedge clk); #2; reset = 1'b1;
        wait_vs(1);
        wait_clk(10);
        check("lock_after_vs1", locked, 0);
        dual_req = 1;
        wait_vs(1);
        wait_clk(5);
        check("lock_after_vs2", locked, 1);
        check("lock_latency", lk_rise - vs_cyc, 3);
        check("lock_err_h", err_h, 0);
    endtask

    initial begin
        wait_clk(5);
        check("rst_locked", locked, 0);
        check("rst_outputs", {pix_valid, frame_start, err_h, err_v, pix_x, pix_y, rgb_o}, 0);
        lock_seq();

        n_strobe = 0; n_fs = 0; n_last = 0; valid_bad = 0; data_bad = 0; color_bad = 0;
        win = 1;
        wait_vs(3);
        win = 0;
        check("strobes_3fr", n_strobe, 3 * HD * VD);
        check("frame_starts", n_fs, 3);
        check("valid_timing", valid_bad, 0);
        check("coord_data", data_bad, 0);
        check("colour_align", color_bad, 0);
        check("last_pixel_rgb", n_last, 3 * VD);
        check("clean_err_h", err_h, 0);
        check("clean_err_v", err_v, 0);

        wait_clk(110);
        #1 reset = 1'b0;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_outputs", {pix_valid, frame_start, err_h, err_v, pix_x, pix_y, rgb_o}, 0);
        wait_clk(3);
        lock_seq();

        shift_req = 1;
        wait_mark();
        wait_clk(6);
        check("shift_err_h", err_h, 1);
        check("shift_err_time", eh_rise - mark_cyc, 3);
        check("shift_unlock_time", lk_fall - mark_cyc, 3);
        check("shift_err_v", err_v, 0);
        wait_vs(1);
        wait_clk(5);
        check("shift_relock", locked, 1);
        check("shift_err_v_after", err_v, 0);
        pulse_clr();
        check("shift_clr", err_h, 0);

        skip_req = 1;
        wait_mark();
        wait_clk(6);
        check("hmiss_err_h", err_h, 1);
        check("hmiss_err_time", eh_rise - mark_cyc, 3);
        wait_vs(1);
        wait_clk(5);
        check("hmiss_relock", locked, 1);

        skip_req = 1;
        wait_mark();
        @(posedge clk); #2;
        @(posedge clk); #2; err_clr = 1'b1;
        @(posedge clk); #2; err_clr = 1'b0;
        wait_clk(2);
        check("clr_vs_new_err", err_h, 1);
        check("clr_vs_new_unlock", lk_fall - mark_cyc, 3);
        wait_vs(1);
        wait_clk(5);
        pulse_clr();
        check("hmiss_clr", err_h, 0);

        vskip_req = 1;
        wait_mark();
        wait_clk(6);
        check("vmiss_err_v", err_v, 1);
        check("vmiss_err_time", ev_rise - mark_cyc, 3);
        check("vmiss_err_h", err_h, 0);
        check("vmiss_unlock", locked, 0);
        pulse_clr();
        check("vmiss_clr", err_v, 0);
        wait_vs(1);
        wait_clk(5);
        check("vmiss_relock", locked, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_rx.md
# vga_rx

VGA stream receiver: the sink end of the text-mode VGA output. It takes the hsync/vsync/3-bit RGB stream produced by the display path, locks its own pixel and line counters to the sync pulses, and re-emits each visible pixel as a coordinate-tagged sample. Sync errors are reported through sticky flags. It is used for loopback self-test of the display path and as the front end of a future frame grabber.

## Interface
- CLK_PER_PIX, 4: clock cycles per pixel; 100 MHz clk gives a 25 MHz pixel rate.
- H_DISPLAY, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing, in pixels.
- V_DISPLAY, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing, in lines.
- SYNC_POL, 1'b1: asserted level of hsync_i and vsync_i. Default is active-high, matching the display path.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- hsync_i  in  1  horizontal sync from the stream, asynchronous to clk.
- vsync_i  in  1  vertical sync from the stream, asynchronous to clk.
- rgb_i  in  3  pixel colour from the stream.
- err_clr  in  1  single-cycle pulse that clears err_h and err_v.
- pix_valid  out  1  one-cycle strobe, once per visible pixel.
- pix_x  out  10  column of the current sample, 0..639.
- pix_y  out  10  row of the current sample, 0..479.
- rgb_o  out  3  colour of the current sample.
- frame_start  out  1  pulse coincident with pix_valid for pixel (0,0).
- locked  out  1  high while the counters track the stream.
- err_h  out  1  sticky flag: horizontal sync mismatch.
- err_v  out  1  sticky flag: vertical sync mismatch.

## Operation
- **Input capture:** hsync_i and vsync_i each pass through a 2-flop synchroniser. rgb_i passes through 2 plain registers, so colour stays aligned with sync.
- **Edge detection:** hs_edge and vs_edge are single-clock pulses on the transition to the SYNC_POL level, detected after synchronisation.
- **Counters:**
  - ph counts 0..CLK_PER_PIX-1.
  - hc counts 0..799 and advances when ph wraps.
  - vc counts 0..524 and advances when hc wraps.
  - All three wrap to 0.
- **Reference points:**
  - The clock carrying hs_edge is phase 0 of pixel H_DISPLAY+H_FRONT (656).
  - The clock carrying vs_edge is phase 0 of pixel 0 of line V_DISPLAY+V_FRONT (490).
- **Resync:**
  - hs_edge loads ph=1, hc=656.
  - vs_edge loads ph=1, hc=0, vc=490.
  - vs_edge takes precedence if both occur on the same clock.
- **State machine:**
  - SEARCH: counters are held at 0. The first vs_edge performs a resync and moves to ACQUIRE.
  - ACQUIRE: every hs_edge and vs_edge resyncs the counters without raising any error. A vs_edge arriving when the free-running counters already read ph=0, hc=0, vc=490 moves to LOCKED.
  - LOCKED: any of the following performs a resync, sets the matching sticky error and moves to ACQUIRE:
    - hs_edge arrives while (ph,hc) is not (0,656): sets err_h.
    - (ph,hc) reaches (0,656) with no hs_edge: sets err_h.
    - vs_edge arrives while (ph,hc,vc) is not (0,0,490): sets err_v.
    - (ph,hc,vc) reaches (0,0,490) with no vs_edge: sets err_v.
- **Sample generation:** pix_valid=1 when state is LOCKED, ph==0, hc<640 and vc<480. On that clock pix_x=hc, pix_y=vc and rgb_o is the 2-stage-delayed rgb_i.
- **Registered outputs:** pix_valid, pix_x, pix_y, rgb_o and frame_start are registered. pix_x, pix_y and rgb_o hold their value between strobes.
- **Error flags:**
  - err_h and err_v stay set until err_clr or reset.
  - If err_clr and a new error occur on the same clock, the flag ends up set.

## Timing
- **Reset:** while reset=0, all outputs are 0, state is SEARCH, and the synchronisers and counters are cleared. Reset takes effect asynchronously and releases on the next clk edge. A reset mid-frame drops locked immediately.
- **Latency:** 3 clk from an rgb_i or sync pin change to the affected registered output (2 synchroniser stages + 1 output register).
- **pix_valid rate:**
  - One strobe every CLK_PER_PIX clocks during a visible line.
  - 640 strobes per line, 307200 per frame.
  - No strobes in blanking.
- **Lock time:** locked rises on the second vs_edge after reset in a clean stream, i.e. one frame after the first vs_edge.
- **Relock:** after a horizontal-only error, the next in-frame vs_edge relocks, since vc keeps running.
- **Error timing:** err_h and err_v rise 1 clk after the offending edge or the missing-edge point.
- **locked timing:** locked falls in that same cycle.

## Test plan
- **Reset:** drive reset=0 mid-stream -> all outputs 0 within the same cycle; after release, locked=0 until 2 vs_edges have been seen.
- **Clean stream:** 640x480 stream with CLK_PER_PIX=4 -> locked at the 2nd vsync; 307200 pix_valid per frame; frame_start exactly once per frame, with pix_x=0, pix_y=0; err_h=err_v=0 over 3 frames.
- **Colour alignment:** stream with rgb_i = pix_x[2:0] of the source -> every strobe has rgb_o == pix_x[2:0]; the last pixel of each line reports (639, y, 3'b111).
- **hsync shifted:** while locked, delay one hsync pulse by 1 pixel -> err_h=1 and locked=0 one clk after the edge; relock at the next vsync; err_v stays 0.
- **hsync/vsync missing:**
  - Suppress one hsync pulse -> err_h=1 at the expected point (ph=0, hc=656).
  - Suppress one vsync pulse -> err_v=1 at (0,0,490).
  - err_clr pulse afterwards -> flag returns to 0.
- **Simultaneous events:** hs_edge and vs_edge in the same clock during ACQUIRE -> counters load hc=0, vc=490. err_clr on the same clock as a new mismatch -> flag remains 1.
